// File: rtl/llc_set_writeback.sv
// Drains one buffered LLC set: writes each modified way in ascending order, then the eviction pointer.
// Latency: accept, one cycle per modified way, one transition cycle, optional evict cycle, one done cycle.
// Backpressure: mem_wr_ready low holds the current request (way, set, valid) stable until accepted.
module llc_set_writeback #(
    parameter int WAYS         = 16,
    parameter int WAY_BITS     = 4,
    parameter int SET_BITS     = 8,
    parameter int LINE_BITS    = 128,
    parameter int TAG_BITS     = 12,
    parameter int STATE_BITS   = 3,
    parameter int SHARERS_BITS = 16,
    parameter int OWNER_BITS   = 4,
    parameter int HPROT_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_state,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [SET_BITS-1:0]     start_set,
    input  logic [WAYS-1:0]         start_mask,
    input  logic                    start_evict,
    input  logic [WAY_BITS-1:0]     start_evict_way,
    output logic [WAY_BITS-1:0]     buf_rd_way,
    input  logic [LINE_BITS-1:0]    buf_line,
    input  logic [TAG_BITS-1:0]     buf_tag,
    input  logic [STATE_BITS-1:0]   buf_state,
    input  logic [SHARERS_BITS-1:0] buf_sharers,
    input  logic [OWNER_BITS-1:0]   buf_owner,
    input  logic [HPROT_BITS-1:0]   buf_hprot,
    input  logic                    buf_dirty,
    output logic                    mem_wr_valid,
    output logic                    mem_wr_evict_valid,
    input  logic                    mem_wr_ready,
    output logic [SET_BITS-1:0]     mem_wr_set,
    output logic [WAY_BITS-1:0]     mem_wr_way,
    output logic [LINE_BITS-1:0]    mem_wr_line,
    output logic [TAG_BITS-1:0]     mem_wr_tag,
    output logic [STATE_BITS-1:0]   mem_wr_state,
    output logic [SHARERS_BITS-1:0] mem_wr_sharers,
    output logic [OWNER_BITS-1:0]   mem_wr_owner,
    output logic [HPROT_BITS-1:0]   mem_wr_hprot,
    output logic                    mem_wr_dirty,
    output logic [WAY_BITS-1:0]     mem_wr_evict_way,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, WRITE, EVICT, DONE} state_t;

    state_t              state, state_next;
    logic [WAYS-1:0]     pending, pending_next;
    logic                evict_pending, evict_pending_next;
    logic [SET_BITS-1:0] set_q;
    logic [WAY_BITS-1:0] evict_way_q;
    logic [WAY_BITS-1:0] cur_way;
    logic [WAY_BITS-1:0] rd_way;
    logic                idle_ready;

    // Lowest-index pending way wins, giving ascending write order.
    always_comb begin
        cur_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (pending[i]) cur_way = WAY_BITS'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pending       <= '0;
            evict_pending <= 1'b0;
            set_q         <= '0;
            evict_way_q   <= '0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            evict_pending <= evict_pending_next;
            if (state == IDLE && start_valid && !rst_state) begin
                set_q       <= start_set;
                evict_way_q <= start_evict_way;
            end
        end
    end

    always_comb begin
        state_next         = state;
        pending_next       = pending;
        evict_pending_next = evict_pending;
        idle_ready         = 1'b0;
        mem_wr_valid       = 1'b0;
        mem_wr_evict_valid = 1'b0;
        done               = 1'b0;
        rd_way             = '0;
        case (state)
            IDLE: begin
                idle_ready = 1'b1;
                if (start_valid) begin
                    pending_next       = start_mask;
                    evict_pending_next = start_evict;
                    state_next         = WRITE;
                end
            end
            WRITE: begin
                if (pending != '0) begin
                    mem_wr_valid = 1'b1;
                    rd_way       = cur_way;
                    if (mem_wr_ready) pending_next = pending & ~(WAYS'(1) << cur_way);
                end else begin
                    state_next = evict_pending ? EVICT : DONE;
                end
            end
            EVICT: begin
                mem_wr_evict_valid = 1'b1;
                if (mem_wr_ready) begin
                    evict_pending_next = 1'b0;
                    state_next         = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst_state) begin
            state_next         = IDLE;
            pending_next       = '0;
            evict_pending_next = 1'b0;
        end
    end

    // Gate with rst so the block advertises nothing while held in reset.
    assign start_ready      = rst & idle_ready;
    assign busy             = (state != IDLE);
    assign buf_rd_way       = rd_way;
    assign mem_wr_way       = rd_way;
    assign mem_wr_set       = set_q;
    assign mem_wr_evict_way = evict_way_q;
    assign mem_wr_line      = buf_line;
    assign mem_wr_tag       = buf_tag;
    assign mem_wr_state     = buf_state;
    assign mem_wr_sharers   = buf_sharers;
    assign mem_wr_owner     = buf_owner;
    assign mem_wr_hprot     = buf_hprot;
    assign mem_wr_dirty     = buf_dirty;

endmodule

// File: tb/tb_llc_set_writeback.sv
// Randomized bench for llc_set_writeback against a queue-based model of the expected write sequence.
module tb_llc_set_writeback;

    localparam int WAYS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rst_state = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [7:0]   start_set = '0;
    logic [15:0]  start_mask = '0;
    logic         start_evict = 1'b0;
    logic [3:0]   start_evict_way = '0;
    logic [3:0]   buf_rd_way;
    logic [127:0] buf_line;
    logic [11:0]  buf_tag;
    logic [2:0]   buf_state;
    logic [15:0]  buf_sharers;
    logic [3:0]   buf_owner;
    logic [0:0]   buf_hprot;
    logic         buf_dirty;
    logic         mem_wr_valid, mem_wr_evict_valid;
    logic         mem_wr_ready = 1'b0;
    logic [7:0]   mem_wr_set;
    logic [3:0]   mem_wr_way;
    logic [127:0] mem_wr_line;
    logic [11:0]  mem_wr_tag;
    logic [2:0]   mem_wr_state;
    logic [15:0]  mem_wr_sharers;
    logic [3:0]   mem_wr_owner;
    logic [0:0]   mem_wr_hprot;
    logic         mem_wr_dirty;
    logic [3:0]   mem_wr_evict_way;
    logic         busy, done;

    // Set-buffer model: contents per way, read combinationally by buf_rd_way.
    logic [127:0] b_line [WAYS];
    logic [11:0]  b_tag  [WAYS];
    logic [2:0]   b_st   [WAYS];
    logic [15:0]  b_sh   [WAYS];
    logic [3:0]   b_own  [WAYS];
    logic [0:0]   b_hp   [WAYS];
    logic         b_dirty[WAYS];

    assign buf_line    = b_line[buf_rd_way];
    assign buf_tag     = b_tag[buf_rd_way];
    assign buf_state   = b_st[buf_rd_way];
    assign buf_sharers = b_sh[buf_rd_way];
    assign buf_owner   = b_own[buf_rd_way];
    assign buf_hprot   = b_hp[buf_rd_way];
    assign buf_dirty   = b_dirty[buf_rd_way];

    llc_set_writeback dut (
        .clk(clk), .rst(rst), .rst_state(rst_state),
        .start_valid(start_valid), .start_ready(start_ready), .start_set(start_set),
        .start_mask(start_mask), .start_evict(start_evict), .start_evict_way(start_evict_way),
        .buf_rd_way(buf_rd_way), .buf_line(buf_line), .buf_tag(buf_tag), .buf_state(buf_state),
        .buf_sharers(buf_sharers), .buf_owner(buf_owner), .buf_hprot(buf_hprot), .buf_dirty(buf_dirty),
        .mem_wr_valid(mem_wr_valid), .mem_wr_evict_valid(mem_wr_evict_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_set(mem_wr_set), .mem_wr_way(mem_wr_way), .mem_wr_line(mem_wr_line),
        .mem_wr_tag(mem_wr_tag), .mem_wr_state(mem_wr_state), .mem_wr_sharers(mem_wr_sharers),
        .mem_wr_owner(mem_wr_owner), .mem_wr_hprot(mem_wr_hprot), .mem_wr_dirty(mem_wr_dirty),
        .mem_wr_evict_way(mem_wr_evict_way), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_buffers();
        for (int w = 0; w < WAYS; w++) begin
            b_line[w]  = {$urandom, $urandom, $urandom, $urandom};
            b_tag[w]   = 12'($urandom);
            b_st[w]    = 3'($urandom);
            b_sh[w]    = 16'($urandom);
            b_own[w]   = 4'($urandom);
            b_hp[w]    = 1'($urandom);
            b_dirty[w] = 1'($urandom);
        end
    endtask

    // mode 0: ready high, 1: random, 2: toggling, 3: low for first 3 cycles then high.
    task automatic run_txn(input logic [7:0] set, input logic [15:0] mask, input logic ev,
                           input logic [3:0] ev_way, input int mode);
        int exp_q[$];
        int k, n, way_cycles;
        logic got_done;
        exp_q = {};
        for (int i = 0; i < WAYS; i++) if (mask[i]) exp_q.push_back(i);
        if (ev) exp_q.push_back(WAYS);
        k = $countones(mask);
        fill_buffers();
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        start_valid = 1'b1; start_set = set; start_mask = mask;
        start_evict = ev; start_evict_way = ev_way;
        @(negedge clk);
        start_valid = 1'b0; start_mask = $urandom; start_set = $urandom;
        n = 1; way_cycles = 0; got_done = 1'b0;
        while (n < 400 && !got_done) begin
            case (mode)
                0: mem_wr_ready = 1'b1;
                1: mem_wr_ready = 1'($urandom_range(0, 1));
                2: mem_wr_ready = n[0];
                default: mem_wr_ready = (n > 3);
            endcase
            if (mem_wr_valid && mem_wr_evict_valid) chk("both_valids", 1, 0);
            if (done) chk("busy_in_done", busy, 1);
            if (mem_wr_valid) begin
                way_cycles++;
                if (exp_q.size() == 0 || exp_q[0] == WAYS) begin
                    chk("unexpected_way_write", mem_wr_way, 5'd31);
                end else begin
                    chk("way_order", mem_wr_way, exp_q[0]);
                    chk("wr_set", mem_wr_set, set);
                    chk("wr_line", mem_wr_line, b_line[exp_q[0]]);
                    chk("wr_meta", {mem_wr_tag, mem_wr_state, mem_wr_sharers, mem_wr_owner,
                                    mem_wr_hprot, mem_wr_dirty},
                        {b_tag[exp_q[0]], b_st[exp_q[0]], b_sh[exp_q[0]], b_own[exp_q[0]],
                         b_hp[exp_q[0]], b_dirty[exp_q[0]]});
                    if (mem_wr_ready) void'(exp_q.pop_front());
                end
            end
            if (mem_wr_evict_valid) begin
                if (exp_q.size() != 1 || exp_q[0] != WAYS) begin
                    chk("unexpected_evict_write", exp_q.size(), 1);
                end else begin
                    chk("evict_way", mem_wr_evict_way, ev_way);
                    if (mem_wr_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_all_written", exp_q.size(), 0);
                if (mode == 0) chk("done_latency", n, k + 2 + int'(ev));
                if (mode == 3 && k == 1) chk("held_way_cycles", way_cycles, 4);
            end
            @(negedge clk);
            n++;
        end
        mem_wr_ready = 1'b0;
        if (!got_done) chk("done_timeout", 0, 1);
        chk("ready_after_done", start_ready, 1);
        chk("idle_after_done", {busy, done, mem_wr_valid, mem_wr_evict_valid}, 4'b0000);
    endtask

    task automatic run_abort();
        int n;
        logic seen_done;
        fill_buffers();
        @(negedge clk);
        start_valid = 1'b1; start_set = 8'h55; start_mask = 16'h00FF; start_evict = 1'b1;
        start_evict_way = 4'h3; mem_wr_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        n = 0;
        while (n < 20 && !(mem_wr_valid && mem_wr_way == 4'd2)) begin
            @(negedge clk);
            n++;
        end
        chk("abort_at_way2", mem_wr_way, 2);
        rst_state = 1'b1;
        @(negedge clk);
        rst_state = 1'b0;
        chk("abort_valid_drop", {mem_wr_valid, mem_wr_evict_valid, busy}, 3'b000);
        chk("abort_ready", start_ready, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || mem_wr_valid || mem_wr_evict_valid) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_quiet", seen_done, 0);
        run_txn(8'h12, 16'h0001, 1'b0, 4'h0, 0);
    endtask

    task automatic run_async_reset();
        int n;
        @(negedge clk);
        start_valid = 1'b1; start_set = 8'hC3; start_mask = 16'h0001; start_evict = 1'b1;
        start_evict_way = 4'h9; mem_wr_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        n = 0;
        while (n < 20 && !mem_wr_evict_valid) begin
            @(negedge clk);
            n++;
        end
        chk("evict_reached", mem_wr_evict_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {mem_wr_valid, mem_wr_evict_valid, busy, done, start_ready}, 5'b0);
        @(negedge clk);
        rst = 1'b1;
        mem_wr_ready = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", start_ready, 1);
        chk("post_reset_busy", busy, 0);
    endtask

    initial begin
        fill_buffers();
        #12;
        chk("reset_outputs", {mem_wr_valid, mem_wr_evict_valid, busy, done, start_ready}, 5'b0);
        chk("reset_rd_way", buf_rd_way, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", start_ready, 1);
        run_txn(8'h00, 16'h0000, 1'b0, 4'h0, 0);
        run_txn(8'h3A, 16'h8005, 1'b0, 4'h0, 0);
        run_txn(8'h44, 16'h0010, 1'b1, 4'h7, 3);
        run_txn(8'h91, 16'hFFFF, 1'b0, 4'h0, 2);
        run_txn(8'h07, 16'h0000, 1'b1, 4'hE, 0);
        run_abort();
        for (int t = 0; t < 25; t++) begin
            run_txn(8'($urandom), (t % 6 == 0) ? 16'h0 : 16'($urandom),
                    1'($urandom), 4'($urandom), (t % 3 == 0) ? 0 : 1);
        end
        run_async_reset();
        run_txn(8'hA5, 16'h4201, 1'b1, 4'h2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/llc_set_writeback.md
Name: llc_set_writeback

Overview:
- Write-side counterpart of the LLC set buffers: drains one buffered set back into the LLC tag/data/state memories after a request has been processed.
- Walks the ways whose buffer contents were modified, one way per write handshake, then optionally writes the updated eviction-way pointer.
- Sits between the set buffers (read combinationally by way index) and the LLC memory write port.

Parameters:
- WAYS, 16, number of LLC ways.
- WAY_BITS, 4, log2(WAYS).
- SET_BITS, 8, set index width.
- LINE_BITS, 128, cache line width.
- TAG_BITS, 12, tag width.
- STATE_BITS, 3, LLC state width.
- SHARERS_BITS, 16, sharers vector width.
- OWNER_BITS, 4, owner id width.
- HPROT_BITS, 1, hprot width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rst_state  in  1  synchronous abort; returns block to IDLE
- start_valid  in  1  writeback request
- start_ready  out  1  high only in IDLE
- start_set  in  SET_BITS  set to write
- start_mask  in  WAYS  bit i = way i modified
- start_evict  in  1  eviction pointer must be written
- start_evict_way  in  WAY_BITS  new eviction pointer value
- buf_rd_way  out  WAY_BITS  way index presented to set buffers
- buf_line / buf_tag / buf_state / buf_sharers / buf_owner / buf_hprot / buf_dirty  in  respective widths, 1 for dirty  buffer contents of buf_rd_way
- mem_wr_valid  out  1  way write request
- mem_wr_evict_valid  out  1  eviction pointer write request
- mem_wr_ready  in  1  memory accepts a write; shared by both requests
- mem_wr_set  out  SET_BITS  latched set
- mem_wr_way  out  WAY_BITS  way being written
- mem_wr_line, mem_wr_tag, mem_wr_state, mem_wr_sharers, mem_wr_owner, mem_wr_hprot, mem_wr_dirty  out  respective widths  combinational pass-through of buf_* inputs
- mem_wr_evict_way  out  WAY_BITS  latched evict pointer
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low): state IDLE, pending mask 0, evict_pending 0, latched set/evict_way 0. All valids, done and busy are 0. start_ready is 1 once reset is released.
- FSM states: IDLE, WRITE, EVICT, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid: latch set, mask, evict flag and evict way; go to WRITE.
  - No other action in IDLE.
- WRITE:
  - cur_way = lowest-index set bit of pending mask. buf_rd_way = mem_wr_way = cur_way.
  - mem_wr_valid = (pending != 0).
  - On mem_wr_valid && mem_wr_ready, clear pending[cur_way].
  - When pending == 0 at cycle start: go to EVICT if evict_pending, else go to DONE. No write is issued in that cycle.
- Backpressure: while mem_wr_ready is low, valid, way and set stay stable, because pending changes only on a handshake. Data fields track the buffer inputs, which the buffers hold stable while busy.
- EVICT:
  - mem_wr_evict_valid = 1.
  - On mem_wr_ready, clear evict_pending and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. start_ready stays 0 in DONE.
- When idle, buf_rd_way is 0 (and it is 0 when cur_way is undefined).
- mem_wr_valid and mem_wr_evict_valid are never high together.
- Latency with mem_wr_ready held high: accept cycle, then k WRITE cycles for k mask bits, then 1 transition cycle, then 1 EVICT cycle if requested, then 1 DONE cycle.
- Empty mask and no evict: accept, one WRITE cycle with no valid, then DONE.
- rst_state in any state: next cycle IDLE, pending and evict_pending cleared, no done pulse. Valids drop in the cycle after rst_state is asserted. rst_state has priority over start_valid.
- Handshake ordering: ways are written strictly in ascending index order. The eviction pointer is always written last.

Test Plan:
- start_mask=16'h0000, start_evict=0, ready=1 -> no mem_wr_valid; done pulses exactly 2 cycles after accept; start_ready returns the next cycle.
- start_set=8'h3A, start_mask=16'h8005, ready=1 -> writes to ways 0, 2, 15 on consecutive cycles, all with mem_wr_set=8'h3A; data equals the buffer contents for each way; then done.
- start_mask=16'h0010, start_evict=1, evict_way=4'h7, ready low for 3 cycles -> way 4 request held stable for 4 cycles; then evict write with mem_wr_evict_way=7; then done.
- start_mask=16'hFFFF, mem_wr_ready toggling every cycle -> 16 way writes in order 0..15; each valid stays stable until accepted; never both valids high.
- rst_state pulsed while writing way 2 of mask 16'h00FF -> valid drops the next cycle; IDLE; no done; next request with mask 16'h0001 writes only way 0.
- rst deasserted low mid-EVICT -> all outputs 0 immediately (asynchronous); after release, start_ready=1.
